csr_access_sequencer: RTL and testbench

//  Owns the single CSR unit port. Arbitrates between the core (CSRRW/CSRRS/CSRRC) and the trap unit.

---
 rtl/csr_access_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_sequencer.sv
// ---------------------------------------------------------------------------
// csr_access_sequencer
//   Owns the single CSR unit port. Arbitrates between core CSR instructions
//   (CSRRW/CSRRS/CSRRC) and trap entry. It then sequences each access over the
//   CSR unit's en/busy handshake: a one-cycle en pulse, then a wait state
//   until busy is seen.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   core_req_i/op/addr/wdata/wr_en_i   core request, held until core_ack_o
//   core_ack_o, core_err_o, core_rdata_o   completion pulse, read-only error,
//                                old CSR value (held until the next ack)
//   trap_req_i, trap_epc_i/cause_i/tval_i  trap entry request and burst data
//   trap_ack_o, trap_vec_o       completion pulse, aligned MTVEC (held)
//   csr_en_o/we_o/addr_o/data_o  request side of the CSR unit port
//   csr_data_i, csr_busy_i       response side of the CSR unit port
// ---------------------------------------------------------------------------
module csr_access_sequencer #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 12,
   parameter logic [ADDR_W-1:0] ADDR_MEPC   = 12'h341,
   parameter logic [ADDR_W-1:0] ADDR_MCAUSE = 12'h342,
   parameter logic [ADDR_W-1:0] ADDR_MTVAL  = 12'h343,
   parameter logic [ADDR_W-1:0] ADDR_MTVEC  = 12'h305
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic [1:0]        core_op_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   input  logic              core_wr_en_i,
   output logic              core_ack_o,
   output logic              core_err_o,
   output logic [DATA_W-1:0] core_rdata_o,
   input  logic              trap_req_i,
   input  logic [DATA_W-1:0] trap_epc_i,
   input  logic [DATA_W-1:0] trap_cause_i,
   input  logic [DATA_W-1:0] trap_tval_i,
   output logic              trap_ack_o,
   output logic [DATA_W-1:0] trap_vec_o,
   output logic              csr_en_o,
   output logic              csr_we_o,
   output logic [ADDR_W-1:0] csr_addr_o,
   output logic [DATA_W-1:0] csr_data_o,
   input  logic [DATA_W-1:0] csr_data_i,
   input  logic              csr_busy_i
);

   typedef enum logic [3:0] {
      IDLE, C_RD, C_RDW, C_WR, C_WRW, C_DONE, T_WR, T_WRW, T_VEC, T_VECW, T_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_en_q, wr_en_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d;
   logic [DATA_W-1:0] old_q, old_d;
   logic              core_ack_q, core_ack_d, core_err_q, core_err_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic              trap_ack_q, trap_ack_d;
   logic [DATA_W-1:0] trap_vec_q, trap_vec_d;
   logic              csr_en_q, csr_en_d, csr_we_q, csr_we_d;
   logic [ADDR_W-1:0] csr_addr_q, csr_addr_d;
   logic [DATA_W-1:0] csr_data_q, csr_data_d;
   logic [DATA_W-1:0] new_val;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         op_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wr_en_q      <= 1'b0;
         err_q        <= 1'b0;
         epc_q        <= '0;
         cause_q      <= '0;
         tval_q       <= '0;
         old_q        <= '0;
         core_ack_q   <= 1'b0;
         core_err_q   <= 1'b0;
         core_rdata_q <= '0;
         trap_ack_q   <= 1'b0;
         trap_vec_q   <= '0;
         csr_en_q     <= 1'b0;
         csr_we_q     <= 1'b0;
         csr_addr_q   <= '0;
         csr_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_en_q      <= wr_en_d;
         err_q        <= err_d;
         epc_q        <= epc_d;
         cause_q      <= cause_d;
         tval_q       <= tval_d;
         old_q        <= old_d;
         core_ack_q   <= core_ack_d;
         core_err_q   <= core_err_d;
         core_rdata_q <= core_rdata_d;
         trap_ack_q   <= trap_ack_d;
         trap_vec_q   <= trap_vec_d;
         csr_en_q     <= csr_en_d;
         csr_we_q     <= csr_we_d;
         csr_addr_q   <= csr_addr_d;
         csr_data_q   <= csr_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_en_d      = wr_en_q;
      err_d        = err_q;
      epc_d        = epc_q;
      cause_d      = cause_q;
      tval_d       = tval_q;
      old_d        = old_q;
      core_ack_d   = 1'b0;
      core_err_d   = core_err_q;
      core_rdata_d = core_rdata_q;
      trap_ack_d   = 1'b0;
      trap_vec_d   = trap_vec_q;
      csr_en_d     = 1'b0;
      csr_we_d     = 1'b0;
      csr_addr_d   = csr_addr_q;
      csr_data_d   = csr_data_q;
      new_val      = '0;

      unique case (state_q)
         IDLE: begin
            // A busy CSR unit still owns the port; trap entry wins over the core.
            if (!csr_busy_i) begin
               if (trap_req_i) begin
                  epc_d   = trap_epc_i;
                  cause_d = trap_cause_i;
                  tval_d  = trap_tval_i;
                  idx_d   = '0;
                  state_d = T_WR;
               end else if (core_req_i) begin
                  op_d    = core_op_i;
                  addr_d  = core_addr_i;
                  wdata_d = core_wdata_i;
                  wr_en_d = core_wr_en_i;
                  old_d   = '0;
                  // addr[11:10]==2'b11 is the read-only CSR space: reject writes without touching the unit.
                  err_d   = core_wr_en_i && (core_addr_i[ADDR_W-1 -: 2] == 2'b11);
                  state_d = (core_wr_en_i && (core_addr_i[ADDR_W-1 -: 2] == 2'b11)) ? C_DONE : C_RD;
               end
            end
         end
         C_RD:  state_d = C_RDW;
         C_RDW: if (csr_busy_i) begin
            old_d   = csr_data_i;
            state_d = wr_en_q ? C_WR : C_DONE;
         end
         C_WR:  state_d = C_WRW;
         C_WRW: if (csr_busy_i) state_d = C_DONE;
         C_DONE: begin
            core_ack_d   = 1'b1;
            core_err_d   = err_q;
            core_rdata_d = old_q;
            state_d      = IDLE;
         end
         T_WR:  state_d = T_WRW;
         T_WRW: if (csr_busy_i) begin
            if (idx_q == 2'd2) begin
               state_d = T_VEC;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = T_WR;
            end
         end
         T_VEC:  state_d = T_VECW;
         T_VECW: if (csr_busy_i) begin
            old_d   = csr_data_i;
            state_d = T_DONE;
         end
         T_DONE: begin
            trap_ack_d = 1'b1;
            trap_vec_d = {old_q[DATA_W-1:2], 2'b00};
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reserved op 2'b11 falls through to plain write.
      unique case (op_q)
         2'b01:   new_val = old_d | wdata_q;
         2'b10:   new_val = old_d & ~wdata_q;
         default: new_val = wdata_q;
      endcase

      // The bus is decoded from the state being entered so that the registered
      // en/we pulse coincides exactly with the access state.
      unique case (state_d)
         C_RD: begin
            csr_en_d   = 1'b1;
            csr_addr_d = addr_d;
         end
         C_WR: begin
            csr_en_d   = 1'b1;
            csr_we_d   = 1'b1;
            csr_addr_d = addr_d;
            csr_data_d = new_val;
         end
         T_WR: begin
            csr_en_d = 1'b1;
            csr_we_d = 1'b1;
            unique case (idx_d)
               2'd0: begin csr_addr_d = ADDR_MEPC;   csr_data_d = epc_d;   end
               2'd1: begin csr_addr_d = ADDR_MCAUSE; csr_data_d = cause_d; end
               default: begin csr_addr_d = ADDR_MTVAL; csr_data_d = tval_d; end
            endcase
         end
         T_VEC: begin
            csr_en_d   = 1'b1;
            csr_addr_d = ADDR_MTVEC;
         end
         default: ;
      endcase
   end

   assign core_ack_o   = core_ack_q;
   assign core_err_o   = core_err_q;
   assign core_rdata_o = core_rdata_q;
   assign trap_ack_o   = trap_ack_q;
   assign trap_vec_o   = trap_vec_q;
   assign csr_en_o     = csr_en_q;
   assign csr_we_o     = csr_we_q;
   assign csr_addr_o   = csr_addr_q;
   assign csr_data_o   = csr_data_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csr_access_sequencer
//   Directed bench with a scoreboard. Stimulus pushes the expected acks and
//   expected CSR bus accesses into queues. A negedge monitor pops and compares
//   them whenever the DUT pulses an ack or csr_en_o. A small CSR unit model
//   answers each en with a one-cycle busy, after an optional stall.
// ---------------------------------------------------------------------------
module tb_csr_access_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        core_req_i = 1'b0;
   logic [1:0]  core_op_i = '0;
   logic [11:0] core_addr_i = '0;
   logic [31:0] core_wdata_i = '0;
   logic        core_wr_en_i = 1'b0;
   logic        core_ack_o, core_err_o;
   logic [31:0] core_rdata_o;
   logic        trap_req_i = 1'b0;
   logic [31:0] trap_epc_i = '0, trap_cause_i = '0, trap_tval_i = '0;
   logic        trap_ack_o;
   logic [31:0] trap_vec_o;
   logic        csr_en_o, csr_we_o;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_data_o;
   logic [31:0] csr_data_i;
   logic        csr_busy_i;

   always #5 clk_i = ~clk_i;

   csr_access_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_op_i(core_op_i), .core_addr_i(core_addr_i),
      .core_wdata_i(core_wdata_i), .core_wr_en_i(core_wr_en_i),
      .core_ack_o(core_ack_o), .core_err_o(core_err_o), .core_rdata_o(core_rdata_o),
      .trap_req_i(trap_req_i), .trap_epc_i(trap_epc_i), .trap_cause_i(trap_cause_i),
      .trap_tval_i(trap_tval_i), .trap_ack_o(trap_ack_o), .trap_vec_o(trap_vec_o),
      .csr_en_o(csr_en_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
      .csr_data_o(csr_data_o), .csr_data_i(csr_data_i), .csr_busy_i(csr_busy_i)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- CSR unit model ----------------
   logic [31:0] mem [0:4095];
   bit          loaded = 1'b0;
   int          stall_cycles = 0;
   int          cnt;
   logic        pend;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         csr_busy_i <= 1'b0;
         csr_data_i <= '0;
         pend       <= 1'b0;
         cnt        <= 0;
         if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[12'h300] <= 32'h1;
            mem[12'h340] <= 32'hFF;
            mem[12'h304] <= 32'hABCD;
            mem[12'h305] <= 32'h203;
            mem[12'hF14] <= 32'h5;
            loaded       <= 1'b1;
         end
      end else if (csr_en_o) begin
         csr_data_i <= mem[csr_addr_o];
         if (csr_we_o) mem[csr_addr_o] <= csr_data_o;
         pend       <= 1'b1;
         cnt        <= stall_cycles;
         csr_busy_i <= (stall_cycles == 0);
      end else if (pend) begin
         if (csr_busy_i) begin
            csr_busy_i <= 1'b0;
            pend       <= 1'b0;
         end else if (cnt <= 1) begin
            csr_busy_i <= 1'b1;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] data;
      bit          err;
      bit          chk_data;
      int          ack_cyc;
   } ack_t;
   typedef struct {
      bit          we;
      logic [11:0] addr;
      logic [31:0] data;
   } acc_t;

   ack_t core_q[$];
   ack_t trap_q[$];
   acc_t acc_q[$];
   logic prev_en = 1'b0;

   task automatic push_ack(input bit is_trap, input logic [31:0] data, input bit err,
                           input bit chk_data, input int lat);
      ack_t e;
      e.data = data; e.err = err; e.chk_data = chk_data;
      e.ack_cyc = cyc + 1 + lat;   // request driven now, accepted on the next edge
      if (is_trap) trap_q.push_back(e); else core_q.push_back(e);
   endtask

   task automatic push_acc(input bit we, input logic [11:0] addr, input logic [31:0] data);
      acc_t a;
      a.we = we; a.addr = addr; a.data = data;
      acc_q.push_back(a);
   endtask

   always @(negedge clk_i) begin
      ack_t e;
      acc_t a;
      if (!rst_i) begin
         if (core_ack_o) begin
            $display("core ack  cyc=%0d rdata=0x%0h err=%0b", cyc, core_rdata_o, core_err_o);
            if (core_q.size() == 0) check("core_ack_unexpected", 1, 0);
            else begin
               e = core_q.pop_front();
               if (e.chk_data) check("core_rdata", core_rdata_o, e.data);
               check("core_err", core_err_o, e.err);
               check("core_ack_cycle", cyc, e.ack_cyc);
            end
         end
         if (trap_ack_o) begin
            $display("trap ack  cyc=%0d vec=0x%0h", cyc, trap_vec_o);
            if (trap_q.size() == 0) check("trap_ack_unexpected", 1, 0);
            else begin
               e = trap_q.pop_front();
               check("trap_vec", trap_vec_o, e.data);
               check("trap_ack_cycle", cyc, e.ack_cyc);
            end
         end
         if (csr_en_o) begin
            $display("csr access cyc=%0d we=%0b addr=0x%0h data=0x%0h", cyc, csr_we_o, csr_addr_o, csr_data_o);
            check("csr_en_back_to_back", prev_en, 0);
            if (acc_q.size() == 0) check("csr_en_unexpected", 1, 0);
            else begin
               a = acc_q.pop_front();
               check("csr_we", csr_we_o, a.we);
               check("csr_addr", csr_addr_o, a.addr);
               if (a.we) check("csr_wdata", csr_data_o, a.data);
            end
         end
      end
      prev_en = csr_en_o;
   end

   // ---------------- stimulus ----------------
   task automatic core_issue(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wdata, input bit wr_en);
      core_op_i = op; core_addr_i = addr; core_wdata_i = wdata; core_wr_en_i = wr_en;
      core_req_i = 1'b1;
   endtask

   task automatic trap_issue(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] tval);
      trap_epc_i = epc; trap_cause_i = cause; trap_tval_i = tval;
      trap_req_i = 1'b1;
   endtask

   task automatic wait_acks(input string name);
      int n = 0;
      while ((core_req_i || trap_req_i) && n < 200) begin
         @(negedge clk_i);
         if (core_ack_o) core_req_i = 1'b0;
         if (trap_ack_o) trap_req_i = 1'b0;
         n++;
      end
      check({"ack_timeout_", name}, {62'd0, core_req_i, trap_req_i}, 0);
      core_req_i = 1'b0;
      trap_req_i = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, {59'd0, core_ack_o, core_err_o, trap_ack_o, csr_en_o, csr_we_o}, 0);
      check({tag, "_rdata"}, core_rdata_o, 0);
      check({tag, "_vec"}, trap_vec_o, 0);
      check({tag, "_csr_addr"}, csr_addr_o, 0);
      check({tag, "_csr_data"}, csr_data_o, 0);
   endtask

   logic [31:0] saved_mtval;

   initial begin
      repeat (3) @(negedge clk_i);
      check_outputs_zero("reset");
      rst_i = 1'b0;
      @(negedge clk_i);

      // CSRRS 0x300 |= 0x8 on 0x1: read then write 0x9, ack 5 cycles after accept
      push_acc(0, 12'h300, 0); push_acc(1, 12'h300, 32'h9);
      push_ack(0, 32'h1, 0, 1, 5);
      core_issue(2'b01, 12'h300, 32'h8, 1);
      wait_acks("csrrs");

      // CSRRC 0x340 &= ~0xF0 on 0xFF -> 0x0F
      push_acc(0, 12'h340, 0); push_acc(1, 12'h340, 32'h0F);
      push_ack(0, 32'hFF, 0, 1, 5);
      core_issue(2'b10, 12'h340, 32'hF0, 1);
      wait_acks("csrrc");

      // CSRRW with wr_en=0: read only, ack 3 cycles after accept
      push_acc(0, 12'h304, 0);
      push_ack(0, 32'hABCD, 0, 1, 3);
      core_issue(2'b00, 12'h304, 32'h1234, 0);
      wait_acks("read_only_op");

      // write to read-only 0xF14: error ack after 1 cycle, no bus access
      push_ack(0, 0, 1, 0, 1);
      core_issue(2'b00, 12'hF14, 32'h77, 1);
      wait_acks("ro_write");

      // trap burst: MEPC, MCAUSE, MTVAL writes, then MTVEC read; vec aligned
      push_acc(1, 12'h341, 32'h100); push_acc(1, 12'h342, 32'h2);
      push_acc(1, 12'h343, 32'hDEAD); push_acc(0, 12'h305, 0);
      push_ack(1, 32'h200, 0, 0, 9);
      trap_issue(32'h100, 32'h2, 32'hDEAD);
      wait_acks("trap");

      // trap and core together: trap first (9), one IDLE cycle, then the 5-cycle RMW
      push_acc(1, 12'h341, 32'h104); push_acc(1, 12'h342, 32'hB);
      push_acc(1, 12'h343, 32'h0); push_acc(0, 12'h305, 0);
      push_acc(0, 12'h300, 0); push_acc(1, 12'h300, 32'h19);
      push_ack(1, 32'h200, 0, 0, 9);
      push_ack(0, 32'h9, 0, 1, 9 + 1 + 5);
      trap_issue(32'h104, 32'hB, 32'h0);
      core_issue(2'b01, 12'h300, 32'h10, 1);
      wait_acks("trap_core");

      // busy held off 3 cycles on a read: ack delayed by 3
      stall_cycles = 3;
      push_acc(0, 12'h304, 0);
      push_ack(0, 32'hABCD, 0, 1, 3 + 3);
      core_issue(2'b00, 12'h304, 32'h0, 0);
      wait_acks("stall");
      stall_cycles = 0;

      // reset mid-trap, right after the MCAUSE write lands
      saved_mtval = mem[12'h343];
      push_acc(1, 12'h341, 32'h200); push_acc(1, 12'h342, 32'h3);
      trap_issue(32'h200, 32'h3, 32'hBEEF);
      repeat (4) @(negedge clk_i);
      #1 rst_i = 1'b1;
      trap_req_i = 1'b0;
      #1 check_outputs_zero("async_reset");
      repeat (2) @(negedge clk_i);
      check("mtval_unchanged", mem[12'h343], saved_mtval);
      check("mcause_written", mem[12'h342], 32'h3);
      check("mepc_written", mem[12'h341], 32'h200);
      rst_i = 1'b0;
      @(negedge clk_i);

      // sequencer is back in IDLE and serves a fresh read
      push_acc(0, 12'h342, 0);
      push_ack(0, 32'h3, 0, 1, 3);
      core_issue(2'b00, 12'h342, 32'h0, 0);
      wait_acks("after_reset");

      repeat (3) @(negedge clk_i);
      check("mem_300", mem[12'h300], 32'h19);
      check("mem_340", mem[12'h340], 32'h0F);
      check("mem_304", mem[12'h304], 32'hABCD);
      check("mem_F14", mem[12'hF14], 32'h5);
      check("core_q_empty", core_q.size(), 0);
      check("trap_q_empty", trap_q.size(), 0);
      check("acc_q_empty", acc_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
